// File: rtl/load_mem_unit.sv
// load_mem_unit: single-outstanding RV32I load unit.
// Flow: accept a load from the load buffer, issue one read to data memory,
// wait a fixed MEM_LATENCY, extract and extend the addressed byte/half/word,
// then offer the result on the CDB until the arbiter grants it.
// Illegal funct3 values skip the memory read and report an exception.
// Optional build macro LOAD_MISALIGN_TRAP_EN: misaligned LH/LHU/LW also skip
// the read and report an exception. Without it, misaligned offsets are
// truncated (LH/LHU use addr[1], LW ignores addr[1:0]).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no load outstanding, ready for a request
// WAIT   | read issued (or trap pending), counting down memory latency
// RESP   | result held on the CDB until cdb_grant_in
module load_mem_unit #(
  parameter int MEM_LATENCY  = 2,
  parameter int ROB_IX_WIDTH = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    req_valid_in,
  input  logic [31:0]             req_addr_in,
  input  logic [ROB_IX_WIDTH-1:0] req_rob_ix_in,
  input  logic [2:0]              req_funct3_in,
  output logic                    req_ready_out,
  output logic                    mem_rd_en_out,
  output logic [29:0]             mem_addr_out,
  input  logic [31:0]             mem_rdata_in,
  output logic                    cdb_valid_out,
  output logic [ROB_IX_WIDTH-1:0] cdb_rob_ix_out,
  output logic [31:0]             cdb_data_out,
  output logic                    cdb_exc_out,
  input  logic                    cdb_grant_in
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [31:0]             r_addr;
  logic [ROB_IX_WIDTH-1:0] r_rob;
  logic [2:0]              r_funct3;
  logic                    r_trap;
  logic                    r_rd_en;
  logic                    r_cdb_valid;
  logic [ROB_IX_WIDTH-1:0] r_cdb_rob;
  logic [31:0]             r_cdb_data;
  logic                    r_cdb_exc;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_misalign;
  logic                    w_trap;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [31:0]             w_load_data;

  // Ready whenever idle, or when the current result is leaving this cycle.
  always_comb begin
    w_ready  = (r_state == S_IDLE) || ((r_state == S_RESP) && cdb_grant_in);
    w_accept = req_valid_in && w_ready;
  end

  // Classify the incoming request: illegal funct3 and (optionally) misaligned.
  always_comb begin
    w_illegal = (req_funct3_in == 3'b011) || (req_funct3_in == 3'b110) ||
                (req_funct3_in == 3'b111);
`ifdef LOAD_MISALIGN_TRAP_EN
    w_misalign = ((req_funct3_in[1:0] == 2'b01) && req_addr_in[0]) ||
                 ((req_funct3_in == 3'b010) && (req_addr_in[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_trap = w_illegal || w_misalign;
  end

  // Select and extend the addressed lane of the little-endian memory word.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    w_load_data = 32'h0000_0000;
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata_in[7:0];
      2'b01:   w_byte = mem_rdata_in[15:8];
      2'b10:   w_byte = mem_rdata_in[23:16];
      default: w_byte = mem_rdata_in[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = mem_rdata_in;
      3'b100:  w_load_data = {24'h000000, w_byte};
      3'b101:  w_load_data = {16'h0000, w_half};
      default: w_load_data = 32'h0000_0000;
    endcase
  end

  // Load FSM with registered memory strobe and CDB outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= 32'h0000_0000;
      r_rob       <= '0;
      r_funct3    <= 3'b000;
      r_trap      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_cdb_valid <= 1'b0;
      r_cdb_rob   <= '0;
      r_cdb_data  <= 32'h0000_0000;
      r_cdb_exc   <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_WAIT: begin
          if (r_trap) begin
            r_state     <= S_RESP;
            r_cdb_valid <= 1'b1;
            r_cdb_rob   <= r_rob;
            r_cdb_data  <= 32'h0000_0000;
            r_cdb_exc   <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state     <= S_RESP;
            r_cdb_valid <= 1'b1;
            r_cdb_rob   <= r_rob;
            r_cdb_data  <= w_load_data;
            r_cdb_exc   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (cdb_grant_in) begin
            r_state     <= S_IDLE;
            r_cdb_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cdb_valid <= 1'b0;
        end
      endcase

      // An accepted request overrides the RESP->IDLE move, giving back-to-back
      // issue without an idle bubble.
      if (w_accept) begin
        r_state  <= S_WAIT;
        r_addr   <= req_addr_in;
        r_rob    <= req_rob_ix_in;
        r_funct3 <= req_funct3_in;
        r_trap   <= w_trap;
        r_rd_en  <= !w_trap;
        r_cnt    <= CNT_W'(MEM_LATENCY);
      end
    end
  end

  assign req_ready_out  = w_ready;
  assign mem_rd_en_out  = r_rd_en;
  assign mem_addr_out   = r_addr[31:2];
  assign cdb_valid_out  = r_cdb_valid;
  assign cdb_rob_ix_out = r_cdb_rob;
  assign cdb_data_out   = r_cdb_data;
  assign cdb_exc_out    = r_cdb_exc;

endmodule

// File: tb/tb_load_mem_unit.sv
// Testbench for load_mem_unit (default MEM_LATENCY=2, ROB_IX_WIDTH=3).
// Expectations follow LOAD_MISALIGN_TRAP_EN when the build defines it.
module tb_load_mem_unit;

  localparam int LAT = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic [31:0] req_addr_in = 32'h0;
  logic [2:0]  req_rob_ix_in = 3'h0;
  logic [2:0]  req_funct3_in = 3'h0;
  logic        req_ready_out;
  logic        mem_rd_en_out;
  logic [29:0] mem_addr_out;
  logic [31:0] mem_rdata_in = 32'hDEADBEEF;
  logic        cdb_valid_out;
  logic [2:0]  cdb_rob_ix_out;
  logic [31:0] cdb_data_out;
  logic        cdb_exc_out;
  logic        cdb_grant_in = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  rob;
    logic        exc;
  } exp_t;
  exp_t exp_q[$];

  load_mem_unit #(.MEM_LATENCY(LAT), .ROB_IX_WIDTH(3)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_addr_in   (req_addr_in),
    .req_rob_ix_in (req_rob_ix_in),
    .req_funct3_in (req_funct3_in),
    .req_ready_out (req_ready_out),
    .mem_rd_en_out (mem_rd_en_out),
    .mem_addr_out  (mem_addr_out),
    .mem_rdata_in  (mem_rdata_in),
    .cdb_valid_out (cdb_valid_out),
    .cdb_rob_ix_out(cdb_rob_ix_out),
    .cdb_data_out  (cdb_data_out),
    .cdb_exc_out   (cdb_exc_out),
    .cdb_grant_in  (cdb_grant_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    case (wa)
      30'h40:  return 32'h80817F22;
      30'h80:  return 32'h12345678;
      default: return 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory model: word valid exactly LAT cycles after the read-strobe cycle.
  logic        rv [0:LAT-1];
  logic [29:0] ra [0:LAT-1];
  initial for (int i = 0; i < LAT; i++) begin rv[i] = 1'b0; ra[i] = 30'h0; end
  always @(negedge clk_in) begin
    rv[0] <= mem_rd_en_out;
    ra[0] <= mem_addr_out;
    for (int i = 1; i < LAT; i++) begin
      rv[i] <= rv[i-1];
      ra[i] <= ra[i-1];
    end
    mem_rdata_in <= rv[LAT-1] ? mem_word(ra[LAT-1]) : 32'hDEADBEEF;
  end

  // Monitor: compare each granted CDB result against the scoreboard.
  always begin
    @(negedge clk_in);
    #1;
    if (rst_in && cdb_valid_out && cdb_grant_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cdb actual_rob=%0d required=none", cdb_rob_ix_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cdb_data", cdb_data_out, e.data);
        chk("cdb_rob", {29'h0, cdb_rob_ix_out}, {29'h0, e.rob});
        chk("cdb_exc", {31'h0, cdb_exc_out}, {31'h0, e.exc});
      end
    end
  end

  // Drive a request at the current negedge; optionally record its result.
  task automatic issue(input logic [31:0] a, input logic [2:0] f3, input logic [2:0] rob,
                       input logic [31:0] ed, input logic ee, input bit push);
    exp_t e;
    req_valid_in  = 1'b1;
    req_addr_in   = a;
    req_funct3_in = f3;
    req_rob_ix_in = rob;
    if (push) begin
      e.data = ed; e.rob = rob; e.exc = ee;
      exp_q.push_back(e);
    end
  endtask

  // Accept the pending request, check the read strobe and result latency.
  task automatic accept_and_wait(input string nm, input int lat, input logic rd_exp,
                                 input logic [29:0] wa);
    int n;
    #1;
    chk({nm, "_ready"}, {31'h0, req_ready_out}, 32'h1);
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    cdb_grant_in = 1'b0;
    chk({nm, "_rd_en"}, {31'h0, mem_rd_en_out}, {31'h0, rd_exp});
    if (rd_exp) chk({nm, "_mem_addr"}, {2'b00, mem_addr_out}, {2'b00, wa});
    chk({nm, "_valid_early"}, {31'h0, cdb_valid_out}, 32'h0);
    n = 0;
    while (!cdb_valid_out && n < 12) begin
      @(posedge clk_in);
      @(negedge clk_in);
      n++;
      if (n == 1 && rd_exp) chk({nm, "_rd_en_once"}, {31'h0, mem_rd_en_out}, 32'h0);
    end
    chk({nm, "_latency"}, n, lat);
  endtask

  task automatic grant_only();
    cdb_grant_in = 1'b1;
    @(negedge clk_in);
    cdb_grant_in = 1'b0;
  endtask

  task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                         input logic [2:0] rob, input logic [31:0] ed, input logic ee,
                         input int lat, input logic rd_exp);
    issue(a, f3, rob, ed, ee, 1'b1);
    accept_and_wait(nm, lat, rd_exp, a[31:2]);
    grant_only();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hd;
    logic [2:0]  hr;
    logic        he;
    // Reset state
    #12;
    chk("rst_ready", {31'h0, req_ready_out}, 32'h1);
    chk("rst_valid", {31'h0, cdb_valid_out}, 32'h0);
    chk("rst_rd_en", {31'h0, mem_rd_en_out}, 32'h0);
    chk("rst_data", cdb_data_out, 32'h0);
    chk("rst_rob", {29'h0, cdb_rob_ix_out}, 32'h0);
    chk("rst_exc", {31'h0, cdb_exc_out}, 32'h0);
    chk("rst_addr", {2'b00, mem_addr_out}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Grant outside RESP does nothing
    cdb_grant_in = 1'b1;
    @(negedge clk_in);
    cdb_grant_in = 1'b0;
    chk("grant_idle_valid", {31'h0, cdb_valid_out}, 32'h0);
    chk("grant_idle_ready", {31'h0, req_ready_out}, 32'h1);

    // Extraction vectors
    do_load("lw100", 32'h100, 3'b010, 3'd5, 32'h80817F22, 1'b0, 3, 1'b1);
    do_load("lb102", 32'h102, 3'b000, 3'd1, 32'hFFFFFF81, 1'b0, 3, 1'b1);
    do_load("lbu102", 32'h102, 3'b100, 3'd2, 32'h00000081, 1'b0, 3, 1'b1);
    do_load("lh102", 32'h102, 3'b001, 3'd3, 32'hFFFF8081, 1'b0, 3, 1'b1);
    do_load("lhu100", 32'h100, 3'b101, 3'd4, 32'h00007F22, 1'b0, 3, 1'b1);
    do_load("lb101", 32'h101, 3'b000, 3'd6, 32'h0000007F, 1'b0, 3, 1'b1);
    do_load("lb103", 32'h103, 3'b000, 3'd7, 32'hFFFFFF80, 1'b0, 3, 1'b1);
    do_load("lhu102", 32'h102, 3'b101, 3'd0, 32'h00008081, 1'b0, 3, 1'b1);
    do_load("lw200", 32'h200, 3'b010, 3'd3, 32'h12345678, 1'b0, 3, 1'b1);
    do_load("lbu203", 32'h203, 3'b100, 3'd2, 32'h00000012, 1'b0, 3, 1'b1);

    // Illegal funct3
    do_load("f3_110", 32'h100, 3'b110, 3'd6, 32'h0, 1'b1, 1, 1'b0);
    do_load("f3_011", 32'h104, 3'b011, 3'd1, 32'h0, 1'b1, 1, 1'b0);

    // Misaligned loads
`ifdef LOAD_MISALIGN_TRAP_EN
    do_load("lw101", 32'h101, 3'b010, 3'd5, 32'h0, 1'b1, 1, 1'b0);
    do_load("lh101", 32'h101, 3'b001, 3'd4, 32'h0, 1'b1, 1, 1'b0);
`else
    do_load("lw101", 32'h101, 3'b010, 3'd5, 32'h80817F22, 1'b0, 3, 1'b1);
    do_load("lh101", 32'h101, 3'b001, 3'd4, 32'h00007F22, 1'b0, 3, 1'b1);
`endif

    // Hold for 4 cycles, then grant together with a new load
    issue(32'h102, 3'b000, 3'd2, 32'hFFFFFF81, 1'b0, 1'b1);
    accept_and_wait("hold", 3, 1'b1, 30'h40);
    hd = cdb_data_out; hr = cdb_rob_ix_out; he = cdb_exc_out;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      chk("hold_valid", {31'h0, cdb_valid_out}, 32'h1);
      chk("hold_data", cdb_data_out, hd);
      chk("hold_rob_exc", {28'h0, he, hr}, {28'h0, cdb_exc_out, cdb_rob_ix_out});
      chk("hold_ready", {31'h0, req_ready_out}, 32'h0);
    end
    cdb_grant_in = 1'b1;
    issue(32'h100, 3'b010, 3'd7, 32'h80817F22, 1'b0, 1'b1);
    accept_and_wait("b2b", 3, 1'b1, 30'h40);
    grant_only();

    // Reset mid-WAIT abandons the load; late memory data is ignored
    issue(32'h100, 3'b010, 3'd3, 32'h0, 1'b0, 1'b0);
    #1;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, cdb_valid_out}, 32'h0);
    chk("midrst_ready", {31'h0, req_ready_out}, 32'h1);
    chk("midrst_rd_en", {31'h0, mem_rd_en_out}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("late_data_ignored", {31'h0, cdb_valid_out}, 32'h0);
    end

    // One more normal load after reset
    do_load("post_rst", 32'h100, 3'b001, 3'd1, 32'h00007F22, 1'b0, 3, 1'b1);

    repeat (3) @(negedge clk_in);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
